coeff_ram_rd_arbiter: RTL and testbench

//  Shares the read ports of coefficient RAM_S and degree RAM_N between the EVP and EVB evaluation FSMs.

---
 rtl/coeff_ram_rd_arbiter_pkg.sv | 28 ++
 rtl/coeff_ram_rd_arbiter_rr_arb2.sv | 20 ++
 rtl/coeff_ram_rd_arbiter.sv | 157 +++++++++++++++
 tb/tb_coeff_ram_rd_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/coeff_ram_rd_arbiter_pkg.sv
// Shared definitions for the RAM_S/RAM_N read arbiter: state encodings,
// requester IDs and the address-width helper.
`default_nettype none

package coeff_ram_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_GNT_EVP = 2'b01,
    ST_GNT_EVB = 2'b10
  } arb_state_t;

  localparam logic REQ_EVP     = 1'b0;
  localparam logic REQ_EVB     = 1'b1;
  localparam int   BURST_CNT_W = 4;

  function automatic int log2_ceil(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/coeff_ram_rd_arbiter_rr_arb2.sv
// Two-way round-robin picker: on a tie the side not served last wins.
`default_nettype none

module coeff_ram_rd_arbiter_rr_arb2
  import coeff_ram_rd_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       pick
);

  always_comb begin
    pick = REQ_EVP;
    if (req == 2'b11) pick = ~last;
    else if (req[REQ_EVB]) pick = REQ_EVB;
  end

endmodule

`default_nettype wire

// File: rtl/coeff_ram_rd_arbiter.sv
// Shares the RAM_S/RAM_N read ports between EVP and EVB with round-robin
// fairness, burst lock and a max-burst limit; returns per-requester valid strobes.
`default_nettype none

module coeff_ram_rd_arbiter
  import coeff_ram_rd_arbiter_pkg::*;
#(
  parameter int  WORD_SIZE = 16,
  parameter int  S_SIZE    = 88,
  parameter int  N_SIZE    = 8,
  parameter int  MAX_BURST = 4,
  localparam int S_AW      = log2_ceil(S_SIZE),
  localparam int N_AW      = log2_ceil(N_SIZE)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rst_instr,
  input  logic            req_evp,
  input  logic            lock_evp,
  input  logic [S_AW-1:0] addr_s_evp,
  input  logic [N_AW-1:0] addr_n_evp,
  input  logic            req_evb,
  input  logic            lock_evb,
  input  logic [S_AW-1:0] addr_s_evb,
  input  logic [N_AW-1:0] addr_n_evb,
  output logic            gnt_evp,
  output logic            gnt_evb,
  output logic            vld_evp,
  output logic            vld_evb,
  output logic            rd_en_S,
  output logic [S_AW-1:0] rd_addr_S,
  output logic            rd_en_N,
  output logic [N_AW-1:0] rd_addr_N,
  output logic            oob_err
);

  generate
    if (MAX_BURST < 1 || MAX_BURST > 15 || WORD_SIZE < 1) begin : g_param_check
      $error("coeff_ram_rd_arbiter: MAX_BURST must be 1..15 and WORD_SIZE positive");
    end
  endgenerate

  localparam int                     BURST_LAST_I = MAX_BURST - 1;
  localparam logic [BURST_CNT_W-1:0] BURST_LAST   = BURST_LAST_I[BURST_CNT_W-1:0];
  localparam logic [S_AW:0]          S_LIMIT      = S_SIZE[S_AW:0];

  arb_state_t             state_q, state_d;
  logic                   rr_last_q, rr_last_d;
  logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic                   vld_evp_q, vld_evp_d;
  logic                   vld_evb_q, vld_evb_d;
  logic                   oob_q, oob_d;

  logic [1:0]      req_vec;
  logic            pick;
  logic            issue_evp, issue_evb, issue, s_oob;
  logic [S_AW-1:0] addr_s_sel;
  logic [N_AW-1:0] addr_n_sel;

  assign req_vec[REQ_EVP] = req_evp;
  assign req_vec[REQ_EVB] = req_evb;

  coeff_ram_rd_arbiter_rr_arb2 u_rr_arb2 (
    .req  (req_vec),
    .last (rr_last_q),
    .pick (pick)
  );

  // An instruction flush kills the read in the cycle it is seen.
  assign issue_evp = (state_q == ST_GNT_EVP) && req_evp && rst_instr;
  assign issue_evb = (state_q == ST_GNT_EVB) && req_evb && rst_instr;
  assign issue     = issue_evp | issue_evb;

  always_comb begin
    addr_s_sel = '0;
    addr_n_sel = '0;
    if (issue_evp) begin
      addr_s_sel = addr_s_evp;
      addr_n_sel = addr_n_evp;
    end else if (issue_evb) begin
      addr_s_sel = addr_s_evb;
      addr_n_sel = addr_n_evb;
    end
  end

  assign s_oob     = issue && ({1'b0, addr_s_sel} >= S_LIMIT);
  assign rd_en_S   = issue & ~s_oob;
  assign rd_en_N   = issue;
  assign rd_addr_S = addr_s_sel;
  assign rd_addr_N = addr_n_sel;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (|req_vec) state_d = (pick == REQ_EVB) ? ST_GNT_EVB : ST_GNT_EVP;
      end
      ST_GNT_EVP: begin
        if (!req_evp) state_d = req_evb ? ST_GNT_EVB : ST_IDLE;
        else if (req_evb && !lock_evp && burst_cnt_q == BURST_LAST) state_d = ST_GNT_EVB;
      end
      ST_GNT_EVB: begin
        if (!req_evb) state_d = req_evp ? ST_GNT_EVP : ST_IDLE;
        else if (req_evp && !lock_evb && burst_cnt_q == BURST_LAST) state_d = ST_GNT_EVP;
      end
      default: state_d = ST_IDLE;
    endcase

    burst_cnt_d = burst_cnt_q;
    if (state_d != state_q) burst_cnt_d = '0;
    else if (issue && burst_cnt_q != BURST_LAST) burst_cnt_d = burst_cnt_q + 1'b1;

    rr_last_d = rr_last_q;
    if (state_d == ST_GNT_EVP && state_q != ST_GNT_EVP) rr_last_d = REQ_EVP;
    if (state_d == ST_GNT_EVB && state_q != ST_GNT_EVB) rr_last_d = REQ_EVB;

    vld_evp_d = issue_evp;
    vld_evb_d = issue_evb;
    oob_d     = oob_q | s_oob;

    if (!rst_instr) begin
      state_d     = ST_IDLE;
      rr_last_d   = REQ_EVB;
      burst_cnt_d = '0;
      vld_evp_d   = 1'b0;
      vld_evb_d   = 1'b0;
      oob_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      rr_last_q   <= REQ_EVB;
      burst_cnt_q <= '0;
      vld_evp_q   <= 1'b0;
      vld_evb_q   <= 1'b0;
      oob_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      burst_cnt_q <= burst_cnt_d;
      vld_evp_q   <= vld_evp_d;
      vld_evb_q   <= vld_evb_d;
      oob_q       <= oob_d;
    end
  end

  assign gnt_evp = (state_q == ST_GNT_EVP);
  assign gnt_evb = (state_q == ST_GNT_EVB);
  assign vld_evp = vld_evp_q;
  assign vld_evb = vld_evb_q;
  assign oob_err = oob_q;

endmodule

`default_nettype wire

// File: tb/tb_coeff_ram_rd_arbiter.sv
// Randomized bench for coeff_ram_rd_arbiter against a tenure-based reference model.
`default_nettype none

module tb_coeff_ram_rd_arbiter;

  localparam int MAXB  = 4;
  localparam int SSIZE = 88;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rst_instr = 1'b1;
  logic       req_evp = 1'b0, lock_evp = 1'b0, req_evb = 1'b0, lock_evb = 1'b0;
  logic [6:0] addr_s_evp = '0, addr_s_evb = '0;
  logic [2:0] addr_n_evp = '0, addr_n_evb = '0;
  logic       gnt_evp, gnt_evb, vld_evp, vld_evb, rd_en_S, rd_en_N, oob_err;
  logic [6:0] rd_addr_S;
  logic [2:0] rd_addr_N;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: current owner (-1 = nobody), who was served last,
  // reads done in this tenure, sticky error and strobes owed next cycle.
  int m_own, m_last, m_reads;
  bit m_oob;
  bit m_pend[2];

  always #5 clk = ~clk;

  coeff_ram_rd_arbiter #(
    .WORD_SIZE (16),
    .S_SIZE    (SSIZE),
    .N_SIZE    (8),
    .MAX_BURST (MAXB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rst_instr  (rst_instr),
    .req_evp    (req_evp),
    .lock_evp   (lock_evp),
    .addr_s_evp (addr_s_evp),
    .addr_n_evp (addr_n_evp),
    .req_evb    (req_evb),
    .lock_evb   (lock_evb),
    .addr_s_evb (addr_s_evb),
    .addr_n_evb (addr_n_evb),
    .gnt_evp    (gnt_evp),
    .gnt_evb    (gnt_evb),
    .vld_evp    (vld_evp),
    .vld_evb    (vld_evb),
    .rd_en_S    (rd_en_S),
    .rd_addr_S  (rd_addr_S),
    .rd_en_N    (rd_en_N),
    .rd_addr_N  (rd_addr_N),
    .oob_err    (oob_err)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own   = -1;
    m_last  = 1;
    m_reads = 0;
    m_oob   = 1'b0;
    m_pend[0] = 1'b0;
    m_pend[1] = 1'b0;
  endtask

  // One clock: drive inputs at the falling edge, compare against the model,
  // then advance the model across the rising edge.
  task automatic step(input logic rp, input logic lp, input logic [6:0] ap, input logic [2:0] np,
                      input logic rb, input logic lb, input logic [6:0] ab, input logic [2:0] nb,
                      input logic ri);
    logic       r[2];
    logic       l[2];
    logic [6:0] as[2];
    logic [2:0] an[2];
    bit         iss, bad;
    int         nxt, y;
    r[0] = rp; r[1] = rb; l[0] = lp; l[1] = lb;
    as[0] = ap; as[1] = ab; an[0] = np; an[1] = nb;
    @(negedge clk);
    req_evp = rp; lock_evp = lp; addr_s_evp = ap; addr_n_evp = np;
    req_evb = rb; lock_evb = lb; addr_s_evb = ab; addr_n_evb = nb;
    rst_instr = ri;
    #1;
    iss = (m_own >= 0) && r[m_own] && ri;
    bad = iss && (int'(as[m_own]) >= SSIZE);
    check_val("gnt_evp", {31'b0, gnt_evp}, {31'b0, m_own == 0});
    check_val("gnt_evb", {31'b0, gnt_evb}, {31'b0, m_own == 1});
    check_val("vld_evp", {31'b0, vld_evp}, {31'b0, m_pend[0]});
    check_val("vld_evb", {31'b0, vld_evb}, {31'b0, m_pend[1]});
    check_val("rd_en_N", {31'b0, rd_en_N}, {31'b0, iss});
    check_val("rd_en_S", {31'b0, rd_en_S}, {31'b0, iss && !bad});
    check_val("oob_err", {31'b0, oob_err}, {31'b0, m_oob});
    if (iss) begin
      check_val("rd_addr_N", {29'b0, rd_addr_N}, {29'b0, an[m_own]});
      if (!bad) check_val("rd_addr_S", {25'b0, rd_addr_S}, {25'b0, as[m_own]});
    end else begin
      check_val("rd_addr_N_idle", {29'b0, rd_addr_N}, 32'd0);
      check_val("rd_addr_S_idle", {25'b0, rd_addr_S}, 32'd0);
    end
    @(posedge clk);
    if (!ri) begin
      model_reset();
    end else begin
      m_pend[0] = iss && (m_own == 0);
      m_pend[1] = iss && (m_own == 1);
      if (bad) m_oob = 1'b1;
      if (iss) m_reads++;
      if (m_own < 0) begin
        if (r[0] && r[1]) nxt = 1 - m_last;
        else if (r[0])    nxt = 0;
        else if (r[1])    nxt = 1;
        else              nxt = -1;
      end else begin
        y = 1 - m_own;
        if (!r[m_own])                                   nxt = r[y] ? y : -1;
        else if (r[y] && !l[m_own] && m_reads >= MAXB)   nxt = y;
        else                                             nxt = m_own;
      end
      if (nxt != m_own) begin
        m_reads = 0;
        if (nxt >= 0) m_last = nxt;
      end
      m_own = nxt;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 7'd0, 3'd0, 0, 0, 7'd0, 3'd0, 1);
  endtask

  initial begin
    bit want[2];
    bit lk[2];

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("reset_gnt", {30'b0, gnt_evp, gnt_evb}, 32'd0);
    check_val("reset_vld", {30'b0, vld_evp, vld_evb}, 32'd0);
    check_val("reset_rd", {30'b0, rd_en_S, rd_en_N}, 32'd0);
    check_val("reset_oob", {31'b0, oob_err}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Single EVP stream with consecutive addresses.
    for (int i = 0; i < 4; i++) step(1, 0, 7'(4 + i), 3'(i), 0, 0, 7'd0, 3'd0, 1);
    idle(3);

    // Both requesting, unlocked: alternating bursts.
    for (int i = 0; i < 18; i++) step(1, 0, 7'(10 + i), 3'(i), 1, 0, 7'(40 + i), 3'(7 - (i % 8)), 1);
    idle(3);

    // EVP locked for a long burst while EVB waits, then EVP releases.
    for (int i = 0; i < 10; i++) step(1, 1, 7'(i), 3'd1, 1, 0, 7'd50, 3'd2, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 7'd0, 3'd0, 1, 0, 7'(60 + i), 3'd3, 1);

    // Out-of-range S address from EVB, then flushed by rst_instr.
    step(0, 0, 7'd0, 3'd0, 1, 0, 7'd88, 3'd5, 1);
    step(0, 0, 7'd0, 3'd0, 1, 0, 7'd87, 3'd6, 1);
    idle(2);
    step(0, 0, 7'd0, 3'd0, 0, 0, 7'd0, 3'd0, 0);
    idle(1);

    // Flush in the middle of an EVB burst.
    for (int i = 0; i < 3; i++) step(0, 0, 7'd0, 3'd0, 1, 0, 7'(20 + i), 3'd4, 1);
    step(0, 0, 7'd0, 3'd0, 1, 0, 7'd30, 3'd4, 0);
    idle(2);

    // EVP drops while EVB waits: direct hand-over.
    for (int i = 0; i < 2; i++) step(1, 0, 7'(i), 3'd0, 1, 1, 7'd70, 3'd1, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 7'd0, 3'd0, 1, 1, 7'(71 + i), 3'd2, 1);
    idle(2);

    // Asynchronous reset asserted mid-cycle during a burst.
    for (int i = 0; i < 3; i++) step(1, 0, 7'(33 + i), 3'd7, 0, 0, 7'd0, 3'd0, 1);
    #3;
    rst = 1'b0;
    #1;
    check_val("async_gnt", {30'b0, gnt_evp, gnt_evb}, 32'd0);
    check_val("async_vld", {30'b0, vld_evp, vld_evb}, 32'd0);
    check_val("async_rd", {30'b0, rd_en_S, rd_en_N}, 32'd0);
    check_val("async_oob", {31'b0, oob_err}, 32'd0);
    @(negedge clk);
    req_evp = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic with held requests and occasional locks and flushes.
    want[0] = 0; want[1] = 0; lk[0] = 0; lk[1] = 0;
    for (int c = 0; c < 2000; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (want[k]) want[k] = ($urandom_range(0, 7) != 0);
        else         want[k] = ($urandom_range(0, 3) == 0);
        if (lk[k]) lk[k] = ($urandom_range(0, 5) != 0);
        else       lk[k] = ($urandom_range(0, 15) == 0);
      end
      step(want[0], lk[0], 7'($urandom_range(0, 95)), 3'($urandom_range(0, 7)),
           want[1], lk[1], 7'($urandom_range(0, 95)), 3'($urandom_range(0, 7)),
           $urandom_range(0, 39) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
